// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU command sequencer: operand and
//               result widths, opcode encodings, divide-by-zero saturation
//               value and the sequencer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W   = 3;
    localparam int OPND_W = 16;
    localparam int RES_W  = 32;

    // One FIFO entry is {op, a, b}
    localparam int CMD_W  = OP_W + 2 * OPND_W;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
    localparam logic [OP_W-1:0] OP_NOTB = 3'b111;

    localparam logic [RES_W-1:0] DIV0_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous command FIFO. Head entry is presented
//               combinationally on o_rd_data; pointers carry one extra bit so
//               full and empty can be told apart after wrap-around.
// Ports       : clk, rst (async, active-high)
//               i_push / i_wr_data : write side (ignored when full)
//               i_pop  / o_rd_data : read side  (ignored when empty)
//               o_full / o_empty   : occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command front-end for the external 16/32-bit ALU. Buffers
//               commands, drives the ALU from registers for ALU_LAT cycles,
//               then captures the result (saturated with error flag on
//               divide-by-zero) for a valid/ready consumer.
// Ports       : cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op : command input
//               alu_a/alu_b/alu_op/alu_out             : ALU interface
//               res_valid/res_ready/res_data/res_op/res_err : result output
//               stat_ops/stat_div0 : handshake counters (ALU_SEQ_STATS_EN)
// Config      : `define ALU_SEQ_STATS_EN to add the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [OP_W-1:0]   res_op,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_div0,
`endif
    output logic              res_err
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [CMD_W-1:0] w_fifo_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_capture;
    logic             w_res_clr;
    logic             w_div0;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (cmd_valid),
        .i_wr_data ({cmd_op, cmd_a, cmd_b}),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign cmd_ready = !w_full;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_div0    = (alu_op == OP_DIV) && (alu_b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_res_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                // Capture on the edge where the settle count reaches ALU_LAT
                if (w_cnt_inc == CNT_W'(ALU_LAT)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_res_clr = 1'b1;
                    if (!w_empty) begin
                        // Back-to-back: reload the ALU on the handshake edge
                        w_pop       = 1'b1;
                        w_state_nxt = EXEC;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            r_cnt     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                alu_op <= w_fifo_rd[CMD_W-1 -: OP_W];
                alu_a  <= w_fifo_rd[2*OPND_W-1 -: OPND_W];
                alu_b  <= w_fifo_rd[OPND_W-1:0];
                r_cnt  <= '0;
            end else if (r_state == EXEC) begin
                r_cnt  <= w_cnt_inc;
            end

            if (w_capture) begin
                res_valid <= 1'b1;
                res_op    <= alu_op;
                if (w_div0) begin
                    res_data <= DIV0_SAT;
                    res_err  <= 1'b1;
                end else begin
                    res_data <= alu_out;
                    res_err  <= 1'b0;
                end
            end else if (w_res_clr) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_div0 <= '0;
        end else if (res_valid && res_ready) begin
            stat_ops <= stat_ops + 1'b1;
            if (res_err) stat_div0 <= stat_div0 + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a behavioural
//               ALU stub, a result scoreboard, directed vector table,
//               multi-cycle corner sequences and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_data;
    logic [2:0]  res_op;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_div0;
`endif

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
`ifdef ALU_SEQ_STATS_EN
        .stat_ops  (stat_ops),
        .stat_div0 (stat_div0),
`endif
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; division by zero returns junk the sequencer must ignore
    function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
        logic [31:0] x, y;
        x = {16'h0, a};
        y = {16'h0, b};
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_MUL:  return x * y;
            OP_DIV:  return (b == 16'h0) ? 32'hDEAD_BEEF : x / y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_NOTA: return {16'h0, ~a};
            default: return {16'h0, ~b};
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_op);

    typedef struct {
        logic [31:0] data;
        logic [2:0]  op;
        logic        err;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [31:0] d;
        logic        err;
    } vec_t;

    res_t exp_q[$];
    res_t m_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_count = 0;
    int   div0_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the command alone
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] op);
        res_t r;
        r.op = op;
        if (op == OP_DIV && b == 16'h0) begin
            r.data = 32'hFFFF_FFFF;
            r.err  = 1'b1;
        end else begin
            r.data = alu_fn(a, b, op);
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard: every result handshake must match the oldest accepted command
    always @(negedge clk) begin
        if (rst) begin
            hs_count   = 0;
            div0_count = 0;
        end else if (res_valid && res_ready) begin
            hs_count++;
            if (res_err) div0_count++;
            if (exp_q.size() == 0) begin
                chk("spurious_result", {31'h0, res_valid}, 32'h0);
            end else begin
                m_e = exp_q.pop_front();
                chk("res_data", res_data, m_e.data);
                chk("res_op", {29'h0, res_op}, {29'h0, m_e.op});
                chk("res_err", {31'h0, res_err}, {31'h0, m_e.err});
            end
        end
    end

    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                            input logic [31:0] d, input logic err);
        int   t;
        bit   done;
        res_t r;
        t     = 0;
        done  = 0;
        r.data = d;
        r.op   = op;
        r.err  = err;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(r);
                done = 1;
            end
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 64) begin
                n_vec++;
                n_err++;
                $display("FAIL push_timeout: got cmd_ready=%0b expected 1", cmd_ready);
                done = 1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        res_t r;
        r = model(a, b, op);
        push_cmd(a, b, op, r.data, r.err);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, exp_q.size(), 32'h0);
    endtask

    vec_t tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, second_v, nv;
        logic [31:0] held;

        tbl[0]  = '{16'd150,   16'd50,    OP_SUB,  32'd100,       1'b0};
        tbl[1]  = '{16'd160,   16'd2,     OP_MUL,  32'd320,       1'b0};
        tbl[2]  = '{16'd160,   16'd2,     OP_DIV,  32'd80,        1'b0};
        tbl[3]  = '{16'd10,    16'd0,     OP_DIV,  32'hFFFF_FFFF, 1'b1};
        tbl[4]  = '{16'h0017,  16'h001E,  OP_AND,  32'h0000_0016, 1'b0};
        tbl[5]  = '{16'h0017,  16'h001E,  OP_OR,   32'h0000_001F, 1'b0};
        tbl[6]  = '{16'h00F0,  16'h1234,  OP_NOTA, 32'h0000_FF0F, 1'b0};
        tbl[7]  = '{16'h0001,  16'h0002,  OP_NOTB, 32'h0000_FFFD, 1'b0};
        tbl[8]  = '{16'hFFFF,  16'h0001,  OP_ADD,  32'h0001_0000, 1'b0};
        tbl[9]  = '{16'd3,     16'd5,     OP_SUB,  32'hFFFF_FFFE, 1'b0};
        tbl[10] = '{16'hFFFF,  16'hFFFF,  OP_MUL,  32'hFFFE_0001, 1'b0};
        tbl[11] = '{16'hFFFF,  16'h0010,  OP_DIV,  32'h0000_0FFF, 1'b0};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_alu_regs", {alu_a, alu_b}, 32'h0);

        // Directed vectors, one at a time from idle, with latency check
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_cmd(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].d, tbl[i].err);
            @(posedge clk);
            #1;
            chk("lat_edge_n1", {31'h0, res_valid}, 32'h0);
            @(posedge clk);
            #1;
            chk("lat_edge_n2", {31'h0, res_valid}, 32'h1);
            repeat (2) @(posedge clk);
            #1;
        end
        wait_drain("table_drain");
`ifdef ALU_SEQ_STATS_EN
        chk("stat_ops_table", {16'h0, stat_ops}, 32'd12);
        chk("stat_div0_table", {16'h0, stat_div0}, 32'd1);
`endif

        // Back-to-back commands: results two cycles apart
        push_cmd(16'd160, 16'd2, OP_MUL, 32'd320, 1'b0);
        push_cmd(16'd160, 16'd2, OP_DIV, 32'd80, 1'b0);
        first_v = -1;
        second_v = -1;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                if (nv == 0) first_v = c;
                else if (nv == 1) second_v = c;
                nv++;
            end
        end
        chk("b2b_count", nv, 32'd2);
        chk("b2b_spacing", second_v - first_v, 32'd2);
        wait_drain("b2b_drain");

        // Fill with consumer stalled: 1 in DONE + DEPTH in FIFO
        res_ready = 1'b0;
        push_model(16'd1, 16'd2, OP_ADD);
        push_model(16'd9, 16'd4, OP_SUB);
        push_model(16'd7, 16'd6, OP_MUL);
        push_model(16'd99, 16'd0, OP_DIV);
        push_model(16'd100, 16'd7, OP_DIV);
        chk("full_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        held = res_data;
        cmd_a = 16'd5;
        cmd_b = 16'd5;
        cmd_op = OP_ADD;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_still_blocked", {31'h0, cmd_ready}, 32'h0);
        chk("stall_hold_data", res_data, held);
        chk("stall_hold_valid", {31'h0, res_valid}, 32'h1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_rise_after_pop", {31'h0, cmd_ready}, 32'h1);
        wait_drain("full_drain");

        // Reset while a command executes and another waits in the FIFO
        res_ready = 1'b0;
        push_cmd(16'h0017, 16'h001E, OP_AND, 32'h16, 1'b0);
        push_cmd(16'h0003, 16'h0004, OP_OR, 32'h7, 1'b0);
        rst = 1'b1;
        #2;
        chk("mrst_res_valid", {31'h0, res_valid}, 32'h0);
        chk("mrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("mrst_alu", {alu_a, alu_b}, 32'h0);
        chk("mrst_res", res_data | {26'h0, res_op, res_err, alu_op}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (res_valid) nv++;
        end
        chk("no_result_after_rst", nv, 32'h0);
`ifdef ALU_SEQ_STATS_EN
        chk("stat_ops_rst", {16'h0, stat_ops}, 32'h0);
`endif

        // Randomized traffic with a randomly stalling consumer
        fork
            begin
                logic [15:0] ra, rb;
                logic [2:0]  rop;
                for (int k = 0; k < 60; k++) begin
                    rop = 3'($urandom_range(0, 7));
                    ra  = 16'($urandom);
                    rb  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                    push_model(ra, rb, rop);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    res_ready = ($urandom_range(0, 1) == 1);
                    @(posedge clk);
                    #1;
                end
            end
        join
        res_ready = 1'b1;
        wait_drain("random_drain");
`ifdef ALU_SEQ_STATS_EN
        chk("stat_ops_final", {16'h0, stat_ops}, 32'(hs_count[15:0]));
        chk("stat_div0_final", {16'h0, stat_div0}, 32'(div0_count[15:0]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the 16-bit-operand / 32-bit-result `ALU` block. Accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU's `A`/`B`/`op` inputs from registers. It holds each command for a fixed settle time, then captures `Alu_out` into a result register presented over a second valid/ready handshake. Divide-by-zero is detected here and reported with a saturated result.

## Interface
- `DEPTH`, 4: command FIFO depth, power of two, ≥2.
- `ALU_LAT`, 1: cycles the ALU inputs are held before `alu_out` is sampled, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd_a` in 16: operand A.
- `cmd_b` in 16: operand B.
- `cmd_op` in 3: opcode. Encodings: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 not A, 111 not B.
- `alu_a` out 16, `alu_b` out 16, `alu_op` out 3: registered drive to the ALU.
- `alu_out` in 32: ALU result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 32: captured result.
- `res_op` out 3: opcode that produced `res_data`.
- `res_err` out 1: divide-by-zero flag for this result.

## Operation
- FIFO push on any edge with `cmd_valid && cmd_ready`.
- FIFO pop only by the FSM. There is no bypass: a command pushed at edge N is poppable at edge N+1 at the earliest.
- FSM states:
  - **IDLE**: on the next edge with FIFO non-empty, pop; load `alu_a`/`alu_b`/`alu_op`; clear the settle counter; go to EXEC.
  - **EXEC**: the counter increments each edge. On the edge where it reaches `ALU_LAT`, capture the result, set `res_valid`, and go to DONE.
    - Normal capture: `res_data <= alu_out`, `res_op <= alu_op`, `res_err <= 0`.
    - Divide-by-zero (`alu_op==011 && alu_b==0`): `res_data <= 32'hFFFF_FFFF`, `res_err <= 1`, and `alu_out` is ignored.
  - **DONE**: `res_valid` held high with `res_data`/`res_op`/`res_err` stable until an edge with `res_ready`. On that edge:
    - FIFO non-empty: pop and load the ALU registers in the same edge, then go to EXEC (back-to-back).
    - FIFO empty: go to IDLE.
    - In both cases `res_valid` clears.
- `alu_a`/`alu_b`/`alu_op` keep their last value outside EXEC.
- Arithmetic is performed entirely by the ALU. The sequencer never modifies operands.
- Reset values:
  - All registered outputs are 0 and the state is IDLE.
  - FIFO pointers are cleared, so `cmd_ready` is 1.
- Reset mid-operation: an in-flight command, a pending result and all FIFO contents are discarded. Nothing is emitted after reset deasserts.

## Timing
- Accept edge N → `res_valid` high after edge N+1+`ALU_LAT` (N+2 with default), given an idle FSM and an empty FIFO.
- Throughput with `res_ready` held high: one result every `ALU_LAT`+1 cycles.
- `cmd_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after a pop from full.
- Push and pop on the same edge with a non-full FIFO: count is unchanged and both take effect.
- Pointers wrap modulo `DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Configuration
- `ALU_SEQ_STATS_EN` defined: adds the following outputs, both reset to 0 and wrapping 16'hFFFF→0:
  - `stat_ops` out 16: counts result handshakes (`res_valid && res_ready`).
  - `stat_div0` out 16: counts handshakes with `res_err`.
- Undefined: both ports and both counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `alu_pkg`: opcode constants (`OP_ADD`…`OP_NOTB`), `OP_W=3`, `OPND_W=16`, `RES_W=32`, `DIV0_SAT=32'hFFFF_FFFF`, and the FSM state type (IDLE/EXEC/DONE).
- One sub-module, `alu_cmd_fifo`: parameterised synchronous FIFO, 35-bit entries {op, a, b}, with push/pop/full/empty.

## Test plan
- Push {150, 50, 001}, `res_ready`=1 → `res_valid` after 2 cycles, `res_data`=100, `res_op`=001, `res_err`=0.
- Push {160, 2, 010} then {160, 2, 011} back-to-back, `res_ready`=1 → results 320 then 80, spaced 2 cycles apart.
- Push {10, 0, 011} → `res_data`=32'hFFFF_FFFF, `res_err`=1. With `ALU_SEQ_STATS_EN`, `stat_div0`=1 after the handshake.
- Hold `res_ready`=0 and push 6 commands → `cmd_ready` low after 5 accepted (4 in FIFO, 1 in DONE). Release `res_ready` → all 5 results emerge in order with correct values.
- Push {8'h17, 8'h1E, 100} and assert `rst` during EXEC → all outputs 0, `cmd_ready`=1, and no `res_valid` appears after release.
- With stats enabled, run 65537 result handshakes → `stat_ops`=1 (wrap-around).
